// File: rtl/bus_write_queue_pkg.sv
// Shared adapter definitions: register map, mode values, status layout and
// the queued write-entry format.
package bus_write_queue_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  localparam logic [3:0] REG_MODE    = 4'd0;
  localparam logic [3:0] REG_DATA    = 4'd1;
  localparam logic [3:0] REG_STATUS  = 4'd2;
  localparam logic [3:0] REG_ADDR_LO = 4'd3;
  localparam logic [3:0] REG_ADDR_HI = 4'd4;

  localparam logic [7:0] MODE_TEXT  = 8'h00;
  localparam logic [7:0] MODE_HIRES = 8'h01;
  localparam logic [7:0] MODE_MULTI = 8'h02;

  localparam int STAT_FULL_BIT = 7;
  localparam int STAT_OVF_BIT  = 6;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  function automatic logic [7:0] status_byte(logic full, logic ovf, logic [3:0] lvl);
    logic [7:0] s;
    s = '0;
    s[STAT_FULL_BIT] = full;
    s[STAT_OVF_BIT]  = ovf;
    s[3:0]           = lvl;
    return s;
  endfunction

endpackage

// File: rtl/bus_write_queue_if.sv
// Screen RAM write port: valid/ready handshake carrying one {addr, data} pair.
interface bus_write_queue_if;
  import bus_write_queue_pkg::*;

  logic              mem_wr_valid;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ready;

  modport master (output mem_wr_valid, mem_wr_addr, mem_wr_data, input mem_wr_ready);
  modport slave  (input mem_wr_valid, mem_wr_addr, mem_wr_data, output mem_wr_ready);
endinterface

// File: rtl/bus_write_queue_sync_fifo.sv
// Small ring-buffer FIFO with a registered head word; push into a full queue
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     valid_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == LVL_W'(DEPTH));
  assign valid_o = ~empty_o;
  assign level_o = count_q;
  assign dout_o  = head_q;

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    head_d   = head_q;
    // head mirrors mem_q[rd_ptr]; refill it from storage or straight from din
    if (pop_ok) begin
      if (count_q > LVL_W'(1)) begin
        head_d = mem_q[rd_ptr_q + PTR_W'(1)];
      end else if (push_ok) begin
        head_d = din_i;
      end
    end else if (empty_o && push_ok) begin
      head_d = din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/bus_write_queue.sv
// 6502 bus front end: synchronizes phi2/cs/wren, commits register writes on
// the phi2 falling edge and queues data-port writes for the screen RAM.
module bus_write_queue
  import bus_write_queue_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_ext1_i,
  input  logic                 cs_i,
  input  logic                 wren_i,
  input  logic [3:0]           rs_i,
  input  logic [7:0]           data_in_i,
  output logic [7:0]           data_out_o,
  output logic [7:0]           mode_o,
  bus_write_queue_if.master    mem_wr
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] phi2_sync_q, cs_sync_q, wren_sync_q, vld_sync_q;
  logic                   phi2_prev_q, armed_q;
  logic                   cap_cs_q, cap_wren_q;
  logic [3:0]             cap_rs_q;
  logic [7:0]             cap_data_q;
  logic [7:0]             regs_q [16];
  logic [7:0]             regs_d [16];
  logic                   ovf_q, ovf_d;

  logic                   phi2_s, commit, push, pop;
  logic                   fifo_valid, fifo_empty, fifo_full;
  logic [LVL_W-1:0]       level;
  logic [ADDR_W-1:0]      addr_cur;
  wr_entry_t              wr_entry, head;

  assign phi2_s = phi2_sync_q[SYNC_STAGES-1];

  // armed_q is set only once a genuine post-reset low phi2 sample has been
  // seen, so a bus cycle straddling reset release is never committed
  always_ff @(posedge clk) begin
    if (rst) begin
      phi2_sync_q <= '0;
      cs_sync_q   <= '1;
      wren_sync_q <= '1;
      vld_sync_q  <= '0;
      phi2_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      cap_cs_q    <= 1'b1;
      cap_wren_q  <= 1'b1;
      cap_rs_q    <= '0;
      cap_data_q  <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      phi2_sync_q <= SYNC_STAGES'({phi2_sync_q, clk_ext1_i});
      cs_sync_q   <= SYNC_STAGES'({cs_sync_q, cs_i});
      wren_sync_q <= SYNC_STAGES'({wren_sync_q, wren_i});
      vld_sync_q  <= SYNC_STAGES'({vld_sync_q, 1'b1});
      phi2_prev_q <= phi2_s;
      armed_q     <= armed_q | (vld_sync_q[SYNC_STAGES-1] & ~phi2_s);
      if (phi2_s) begin
        cap_cs_q   <= cs_sync_q[SYNC_STAGES-1];
        cap_wren_q <= wren_sync_q[SYNC_STAGES-1];
        cap_rs_q   <= rs_i;
        cap_data_q <= data_in_i;
      end
      ovf_q  <= ovf_d;
      regs_q <= regs_d;
    end
  end

  assign commit   = phi2_prev_q & ~phi2_s & armed_q & ~cap_cs_q & ~cap_wren_q;
  assign pop      = fifo_valid & mem_wr.mem_wr_ready;
  assign addr_cur = {regs_q[REG_ADDR_HI], regs_q[REG_ADDR_LO]};
  assign wr_entry = '{addr: addr_cur, data: cap_data_q};

  always_comb begin
    regs_d = regs_q;
    ovf_d  = ovf_q;
    push   = 1'b0;
    if (commit) begin
      case (cap_rs_q)
        REG_DATA: begin
          push             = 1'b1;
          regs_d[REG_DATA] = cap_data_q;
          {regs_d[REG_ADDR_HI], regs_d[REG_ADDR_LO]} = addr_cur + ADDR_W'(1);
          if (fifo_full && !pop) ovf_d = 1'b1;
        end
        REG_STATUS: ovf_d = 1'b0;
        default:    regs_d[cap_rs_q] = cap_data_q;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (wr_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .valid_o (fifo_valid),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (level)
  );

  assign mem_wr.mem_wr_valid = fifo_valid;
  assign mem_wr.mem_wr_addr  = head.addr;
  assign mem_wr.mem_wr_data  = head.data;

  assign mode_o     = regs_q[REG_MODE];
  assign data_out_o = (rs_i == REG_STATUS) ? status_byte(fifo_full, ovf_q, 4'(level))
                                           : regs_q[rs_i];

endmodule
